// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: shares one fixed-latency memory port between fetch and load/store,
// data first, with fetch forced through after STARVE_LIMIT consecutive data grants.
module memory_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int MEM_LATENCY = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         if_req_valid,
  input  logic [DATA_WIDTH-1:0]        if_req_addr,
  output logic                         if_req_ready,
  input  logic                         if_flush,
  output logic                         if_rsp_valid,
  output logic [INSTRUCTION_WIDTH-1:0] if_rsp_data,
  input  logic                         ls_req_valid,
  input  logic                         ls_req_write,
  input  logic [DATA_WIDTH-1:0]        ls_req_addr,
  input  logic [DATA_WIDTH-1:0]        ls_req_wdata,
  input  logic [3:0]                   ls_req_byteEn,
  output logic                         ls_req_ready,
  output logic                         ls_rsp_valid,
  output logic [DATA_WIDTH-1:0]        ls_rsp_data,
  output logic                         mem_en,
  output logic                         mem_we,
  output logic [DATA_WIDTH-1:0]        mem_addr,
  output logic [DATA_WIDTH-1:0]        mem_wdata,
  output logic [3:0]                   mem_byteEn,
  input  logic [DATA_WIDTH-1:0]        mem_rdata,
  output logic                         busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state;
  logic [3:0] cnt, streak;
  logic owner_if, write, drop, force_if, idle, st_wr;
  assign idle = state == IDLE;
  assign force_if = streak == 4'(STARVE_LIMIT) && if_req_valid && !if_flush;
  assign ls_req_ready = idle && ls_req_valid && !force_if;
  assign if_req_ready = idle && if_req_valid && !if_flush && (!ls_req_valid || force_if);
  assign st_wr = ls_req_ready && ls_req_write;
  assign busy = !idle;
  assign if_rsp_valid = state == RESP && owner_if && !drop && !if_flush;
  assign ls_rsp_valid = state == RESP && !owner_if;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      streak <= '0;
      owner_if <= 1'b0;
      write <= 1'b0;
      drop <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_byteEn <= '0;
      if_rsp_data <= '0;
      ls_rsp_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ls_req_ready || if_req_ready) begin
            state <= ISSUE;
            mem_en <= 1'b1;
            mem_we <= st_wr;
            write <= st_wr;
            owner_if <= !ls_req_ready;
            mem_addr <= ls_req_ready ? ls_req_addr : if_req_addr;
            mem_wdata <= st_wr ? ls_req_wdata : '0;
            mem_byteEn <= st_wr ? ls_req_byteEn : 4'hf;
          end
          // streak counts data wins only while fetch is actually waiting
          streak <= (ls_req_ready && if_req_valid) ? (streak == 4'(STARVE_LIMIT) ? streak : streak + 4'd1)
                  : ((if_req_ready || !if_req_valid) ? 4'd0 : streak);
        end
        ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          cnt <= 4'(MEM_LATENCY);
          drop <= drop || (owner_if && if_flush);
          state <= WAIT;
        end
        WAIT: begin
          drop <= drop || (owner_if && if_flush);
          if (cnt == 4'd1) begin
            state <= RESP;
            if (owner_if) if_rsp_data <= mem_rdata[INSTRUCTION_WIDTH-1:0];
            else ls_rsp_data <= write ? '0 : mem_rdata;
          end else cnt <= cnt - 4'd1;
        end
        RESP: begin
          state <= IDLE;
          drop <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_memory_port_arbiter.sv
// tb_memory_port_arbiter: directed stimulus, a cycle-offset transaction model checked every cycle,
// and literal expectations for the key scenarios.
module tb_memory_port_arbiter;
  localparam int L = 3;
  localparam int SL = 4;
  logic clk = 1'b0;
  logic reset;
  logic if_req_valid, if_req_ready, if_flush, if_rsp_valid;
  logic [31:0] if_req_addr, if_rsp_data;
  logic ls_req_valid, ls_req_write, ls_req_ready, ls_rsp_valid;
  logic [31:0] ls_req_addr, ls_req_wdata, ls_rsp_data;
  logic [3:0] ls_req_byteEn, mem_byteEn;
  logic mem_en, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  int total = 0;
  int bad = 0;
  int cyc = 0;

  memory_port_arbiter #(.DATA_WIDTH(32), .INSTRUCTION_WIDTH(32), .MEM_LATENCY(L), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_flush(if_flush), .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .ls_req_valid(ls_req_valid), .ls_req_write(ls_req_write), .ls_req_addr(ls_req_addr),
    .ls_req_wdata(ls_req_wdata), .ls_req_byteEn(ls_req_byteEn), .ls_req_ready(ls_req_ready),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_byteEn(mem_byteEn), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int i);
    return (i == 16) ? 32'h00500093 : {16'h1234, 16'(i * 4)};
  endfunction

  // memory macro: byte-written overlay over the initial image, read data valid L cycles after mem_en
  logic [31:0] ew [256] = '{default: '0};
  logic [3:0]  ev [256] = '{default: '0};
  int rd_cnt = 0;
  logic [31:0] rd_data = '0;
  function automatic logic [31:0] env_rd(input int i);
    logic [31:0] w;
    w = init_word(i);
    for (int b = 0; b < 4; b++) if (ev[i][b]) w[8*b +: 8] = ew[i][8*b +: 8];
    return w;
  endfunction
  always @(posedge clk) begin
    if (mem_en && mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_byteEn[b]) begin
          ew[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
          ev[mem_addr[9:2]][b] <= 1'b1;
        end
    if (mem_en) begin
      rd_cnt <= L;
      rd_data <= env_rd(int'(mem_addr[9:2]));
    end else if (rd_cnt != 0) rd_cnt <= rd_cnt - 1;
  end
  assign mem_rdata = (rd_cnt == 1) ? rd_data : 32'hBADC0FFE;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s cycle %0d: got %h want %h", nm, cyc, a, e);
    end
  endtask

  // model: a granted transaction occupies cycles t0..t0+2+L; mem strobe at +1, response at +2+L
  logic [31:0] mm [256];
  initial begin
    bit act, m_if, m_wr, drop_m, e_lsr, e_ifr, e_ifv, e_lsv, frc;
    int t0, k, streak_m;
    logic [31:0] m_addr, m_wdata, exp_d, lif, lls;
    logic [3:0] m_be;
    act = 0; m_if = 0; m_wr = 0; drop_m = 0; t0 = 0; k = 0; streak_m = 0;
    m_addr = 0; m_wdata = 0; m_be = 0; exp_d = 0; lif = 0; lls = 0;
    for (int i = 0; i < 256; i++) mm[i] = init_word(i);
    forever begin
      @(negedge clk);
      if (!reset) begin
        act = 0; drop_m = 0; streak_m = 0; lif = 0; lls = 0;
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_be", mem_byteEn, 0);
      end
      if (!act) begin
        frc = streak_m == SL && if_req_valid && !if_flush;
        e_lsr = ls_req_valid && !frc;
        e_ifr = if_req_valid && !if_flush && (!ls_req_valid || frc);
        e_ifv = 0; e_lsv = 0;
      end else begin
        k = cyc - t0;
        e_lsr = 0; e_ifr = 0;
        if (m_if && if_flush) drop_m = 1;
        if (k == 2 + L) begin
          if (m_if) lif = exp_d; else lls = exp_d;
        end
        e_ifv = k == 2 + L && m_if && !drop_m;
        e_lsv = k == 2 + L && !m_if;
      end
      chk("ls_req_ready", ls_req_ready, e_lsr);
      chk("if_req_ready", if_req_ready, e_ifr);
      chk("busy", busy, act);
      chk("mem_en", mem_en, act && k == 1);
      chk("if_rsp_valid", if_rsp_valid, e_ifv);
      chk("ls_rsp_valid", ls_rsp_valid, e_lsv);
      chk("if_rsp_data", if_rsp_data, lif);
      chk("ls_rsp_data", ls_rsp_data, lls);
      if (act && k == 1) begin
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_we", mem_we, m_wr);
        chk("mem_byteEn", mem_byteEn, m_be);
        if (m_wr) chk("mem_wdata", mem_wdata, m_wdata);
      end
      if (reset) begin
        if (!act) begin
          if (e_lsr || e_ifr) begin
            act = 1; t0 = cyc; m_if = !e_lsr;
            m_wr = e_lsr && ls_req_write;
            m_addr = e_lsr ? ls_req_addr : if_req_addr;
            m_wdata = ls_req_wdata;
            m_be = m_wr ? ls_req_byteEn : 4'hf;
            if (m_wr) begin
              for (int b = 0; b < 4; b++) if (m_be[b]) mm[m_addr[9:2]][8*b +: 8] = m_wdata[8*b +: 8];
              exp_d = 0;
            end else exp_d = mm[m_addr[9:2]];
          end
          if (e_lsr && if_req_valid) streak_m = (streak_m < SL) ? streak_m + 1 : SL;
          else if (e_ifr || !if_req_valid) streak_m = 0;
        end else if (k == 2 + L) begin
          act = 0; drop_m = 0;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input bit ls);
    bit ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      ok = ls ? ls_req_ready : if_req_ready;
    end
    if (!ok) chk("ready_timeout", 0, 1);
  endtask

  task automatic wait_rsp(input bit ls);
    bit ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      ok = ls ? ls_rsp_valid : if_rsp_valid;
    end
    if (!ok) chk("rsp_timeout", 0, 1);
  endtask

  task automatic wait_idle;
    bit ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      ok = !busy;
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, n;
    string s;
    reset = 0; if_req_valid = 0; if_req_addr = 0; if_flush = 0;
    ls_req_valid = 0; ls_req_write = 0; ls_req_addr = 0; ls_req_wdata = 0; ls_req_byteEn = 0;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_mem_en", mem_en, 0);
    chk("reset_if_data", if_rsp_data, 0);
    tick; reset = 1;
    tick; tick;
    // plain fetch: ready at 0, strobe at 1, response at 2+L
    if_req_valid = 1; if_req_addr = 32'h40;
    @(negedge clk);
    chk("f_ready", if_req_ready, 1);
    tick; if_req_valid = 0;
    @(negedge clk);
    chk("f_mem_en", mem_en, 1);
    chk("f_mem_addr", mem_addr, 32'h40);
    chk("f_busy1", busy, 1);
    repeat (4) @(negedge clk);
    chk("f_rsp_valid", if_rsp_valid, 1);
    chk("f_rsp_data", if_rsp_data, 32'h00500093);
    chk("f_busy5", busy, 1);
    @(negedge clk);
    chk("f_busy6", busy, 0);
    // store then load of the same word
    tick; ls_req_valid = 1; ls_req_write = 1; ls_req_addr = 32'h100;
    ls_req_wdata = 32'hDEADBEEF; ls_req_byteEn = 4'b0011;
    wait_ready(1);
    tick; ls_req_valid = 0; ls_req_write = 0;
    @(negedge clk);
    chk("st_mem_we", mem_we, 1);
    chk("st_mem_be", mem_byteEn, 4'b0011);
    wait_rsp(1);
    chk("st_ack_data", ls_rsp_data, 0);
    tick; ls_req_valid = 1; ls_req_addr = 32'h100;
    wait_ready(1);
    tick; ls_req_valid = 0;
    @(negedge clk);
    chk("ld_mem_be", mem_byteEn, 4'hf);
    chk("ld_mem_we", mem_we, 0);
    wait_rsp(1);
    chk("ld_data", ls_rsp_data, 32'h1234BEEF);
    // both requesters hammering: fetch forced in after SL data grants
    wait_idle;
    tick; if_req_valid = 1; if_req_addr = 32'h44; ls_req_valid = 1; ls_req_addr = 32'h200;
    s = "";
    for (int i = 0; i < 100 && s.len() < 6; i++) begin
      @(negedge clk);
      if (ls_req_ready || if_req_ready) chk("one_ready", ls_req_ready && if_req_ready, 0);
      if (ls_req_ready) s = {s, "L"};
      else if (if_req_ready) s = {s, "I"};
    end
    total++;
    if (s != "LLLLIL") begin
      bad++;
      $display("FAIL grant_order got %s want LLLLIL", s);
    end
    tick; if_req_valid = 0; ls_req_valid = 0;
    wait_idle;
    // flush during WAIT kills the fetch response but not its timing
    tick; if_req_valid = 1; if_req_addr = 32'h80;
    wait_ready(0);
    c0 = cyc;
    tick; if_req_valid = 0;
    tick; tick; if_flush = 1;
    tick; if_flush = 0;
    n = 0;
    while (cyc < c0 + 5) begin
      @(negedge clk);
      n += int'(if_rsp_valid);
    end
    chk("fl_busy_resp", busy, 1);
    chk("fl_no_rsp", n, 0);
    @(negedge clk);
    chk("fl_busy_done", busy, 0);
    tick; if_req_valid = 1; if_req_addr = 32'h84;
    wait_ready(0);
    tick; if_req_valid = 0;
    wait_rsp(0);
    chk("fl_next_data", if_rsp_data, 32'h12340084);
    // flush in IDLE blocks the fetch grant only while high
    wait_idle;
    tick; if_req_valid = 1; if_req_addr = 32'h40; if_flush = 1;
    @(negedge clk);
    chk("if_blk0", if_req_ready, 0);
    tick;
    @(negedge clk);
    chk("if_blk1", if_req_ready, 0);
    tick; if_flush = 0;
    @(negedge clk);
    chk("if_unblk", if_req_ready, 1);
    tick; if_req_valid = 0;
    wait_rsp(0);
    wait_idle;
    // asynchronous reset in the middle of WAIT
    tick; ls_req_valid = 1; ls_req_addr = 32'h104;
    wait_ready(1);
    tick; ls_req_valid = 0;
    tick; tick; reset = 0;
    @(negedge clk);
    chk("ar_busy", busy, 0);
    chk("ar_ls_data", ls_rsp_data, 0);
    chk("ar_if_data", if_rsp_data, 0);
    tick; tick; reset = 1; ls_req_valid = 1; ls_req_addr = 32'h108;
    @(negedge clk);
    chk("ar_first_ready", ls_req_ready, 1);
    tick; ls_req_valid = 0;
    wait_rsp(1);
    chk("ar_ld_data", ls_rsp_data, 32'h12340108);
    wait_idle;
    tick; tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
